insn_encoder_loader: RTL and testbench

Inverse of the instruction decoder: accepts instruction fields plus a format tag over a valid/ready handshake and packs them into 32-bit instruction words. Writes each word sequentially into instruction memory through a write port with backpressure.
Used as the program loader / self-test stimulus source ahead of the fetch stage. Contains a load FSM, an address counter and a one-entry output register.

---
 rtl/isa_pkg.sv | 41 ++++
 rtl/insn_encoder_loader_if.sv | 38 +++
 rtl/insn_pack.sv | 43 ++++
 rtl/insn_encoder_loader.sv | 185 ++++++++++++++++++
 tb/tb_insn_encoder_loader.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Shared ISA field layout, format tags and loader FSM states for the encoder/decoder pair.
package isa_pkg;

    localparam int unsigned INSN_W = 32;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 17;
    localparam int unsigned TGT_W  = 27;

    localparam int unsigned OPC_HI   = 31;
    localparam int unsigned OPC_LO   = 27;
    localparam int unsigned RD_HI    = 26;
    localparam int unsigned RD_LO    = 22;
    localparam int unsigned RS_HI    = 21;
    localparam int unsigned RS_LO    = 17;
    localparam int unsigned RT_HI    = 16;
    localparam int unsigned RT_LO    = 12;
    localparam int unsigned SHAMT_HI = 11;
    localparam int unsigned SHAMT_LO = 7;
    localparam int unsigned ALUOP_HI = 6;
    localparam int unsigned ALUOP_LO = 2;
    localparam int unsigned IMM_HI   = 16;
    localparam int unsigned IMM_LO   = 0;
    localparam int unsigned TGT_HI   = 26;
    localparam int unsigned TGT_LO   = 0;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_JI  = 2'd2,
        FMT_JII = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/insn_encoder_loader_if.sv
// Field-bundle input stream plus instruction-memory write port of the loader.
interface insn_encoder_loader_if
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) ();

    logic              in_valid;
    logic              in_ready;
    fmt_e              in_fmt;
    logic [OPC_W-1:0]  in_opcode;
    logic [REG_W-1:0]  in_rd;
    logic [REG_W-1:0]  in_rs;
    logic [REG_W-1:0]  in_rt;
    logic [REG_W-1:0]  in_shamt;
    logic [REG_W-1:0]  in_aluop;
    logic [IMM_W-1:0]  in_imm;
    logic [TGT_W-1:0]  in_target;
    logic              in_last;

    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [INSN_W-1:0] imem_data;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs, in_rt, in_shamt,
               in_aluop, in_imm, in_target, in_last, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_data
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs, in_rt, in_shamt,
               in_aluop, in_imm, in_target, in_last, imem_ready,
        output in_ready, imem_we, imem_addr, imem_data
    );

endinterface

// File: rtl/insn_pack.sv
// Combinational packer: format tag plus instruction fields -> 32-bit instruction word.
module insn_pack
    import isa_pkg::*;
(
    input  fmt_e              fmt,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic [REG_W-1:0]  shamt,
    input  logic [REG_W-1:0]  aluop,
    input  logic [IMM_W-1:0]  imm,
    input  logic [TGT_W-1:0]  target,
    output logic [INSN_W-1:0] insn_c
);

    // Unused bit positions of each format stay zero.
    always_comb begin : pack
        insn_c                 = '0;
        insn_c[OPC_HI:OPC_LO]  = opcode;
        unique case (fmt)
            FMT_R: begin
                insn_c[RD_HI:RD_LO]       = rd;
                insn_c[RS_HI:RS_LO]       = rs;
                insn_c[RT_HI:RT_LO]       = rt;
                insn_c[SHAMT_HI:SHAMT_LO] = shamt;
                insn_c[ALUOP_HI:ALUOP_LO] = aluop;
            end
            FMT_I: begin
                insn_c[RD_HI:RD_LO]   = rd;
                insn_c[RS_HI:RS_LO]   = rs;
                insn_c[IMM_HI:IMM_LO] = imm;
            end
            FMT_JI: begin
                insn_c[TGT_HI:TGT_LO] = target;
            end
            FMT_JII: begin
                insn_c[RD_HI:RD_LO] = rd;
            end
        endcase
    end

endmodule

// File: rtl/insn_encoder_loader.sv
// Program loader: packs field bundles into instruction words and streams them into imem.
// Optional running XOR checksum output when ENC_CHECKSUM_EN is defined.
module insn_encoder_loader
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned WORDS_MAX = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    insn_encoder_loader_if.slave  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_W:0]       word_count
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [INSN_W-1:0]     checksum
`endif
);

    localparam int unsigned        CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0]  ADDR_LAST = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(WORDS_MAX);

    ld_state_e          state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [INSN_W-1:0]  out_data_q, out_data_d;
    logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
    logic [ADDR_W-1:0]  acc_addr_q, acc_addr_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef ENC_CHECKSUM_EN
    logic [INSN_W-1:0]  checksum_q, checksum_d;
`endif

    logic [INSN_W-1:0]  insn_c;
    logic               in_ready_c;
    logic               accept_c;
    logic               wr_done_c;
    logic               start_c;
    logic               cnt_hit_c;
    logic               addr_hit_c;
    logic               end_c;
    logic               ovf_set_c;

    insn_pack u_pack (
        .fmt    (bus.in_fmt),
        .opcode (bus.in_opcode),
        .rd     (bus.in_rd),
        .rs     (bus.in_rs),
        .rt     (bus.in_rt),
        .shamt  (bus.in_shamt),
        .aluop  (bus.in_aluop),
        .imm    (bus.in_imm),
        .target (bus.in_target),
        .insn_c (insn_c)
    );

    // Handshake decode; a session closes on the accept of its last, WORDS_MAX-th or top-address word.
    always_comb begin : handshake
        in_ready_c = (state_q == ST_LOAD) && (!out_valid_q || bus.imem_ready);
        accept_c   = in_ready_c && bus.in_valid;
        wr_done_c  = out_valid_q && bus.imem_ready;
        start_c    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        cnt_hit_c  = (acc_cnt_q + CNT_W'(1)) == CNT_MAX;
        addr_hit_c = acc_addr_q == ADDR_LAST;
        end_c      = accept_c && (bus.in_last || cnt_hit_c || addr_hit_c);
        ovf_set_c  = accept_c && !bus.in_last && (cnt_hit_c || addr_hit_c);
    end

    always_ff @(posedge clock) begin : fsm_reg
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_c) state_d = ST_LOAD;
            ST_LOAD:  if (end_c) state_d = ST_DRAIN;
            ST_DRAIN: if (!out_valid_q || bus.imem_ready) state_d = ST_DONE;
            ST_DONE:  if (start_c) state_d = ST_LOAD;
        endcase
    end

    always_comb begin : fsm_out
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_addr_d   = out_addr_q;
        acc_addr_d   = acc_addr_q;
        acc_cnt_d    = acc_cnt_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
`ifdef ENC_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif
        busy_d       = (state_d == ST_LOAD);
        done_d       = (state_d == ST_DONE);

        if (start_c) begin
            acc_addr_d   = base_addr;
            acc_cnt_d    = '0;
            word_count_d = '0;
            overflow_d   = 1'b0;
`ifdef ENC_CHECKSUM_EN
            checksum_d   = '0;
`endif
        end

        if (wr_done_c) begin
            out_valid_d  = 1'b0;
            word_count_d = word_count_q + CNT_W'(1);
`ifdef ENC_CHECKSUM_EN
            checksum_d   = checksum_q ^ out_data_q;
`endif
        end

        // Accept refills the output register in the same cycle a write retires.
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = insn_c;
            out_addr_d  = acc_addr_q;
            acc_cnt_d   = acc_cnt_q + CNT_W'(1);
            if (!addr_hit_c) begin
                acc_addr_d = acc_addr_q + ADDR_W'(1);
            end
        end

        if (ovf_set_c) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin : data_reg
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
            acc_addr_q   <= '0;
            acc_cnt_q    <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
            acc_addr_q   <= acc_addr_d;
            acc_cnt_q    <= acc_cnt_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef ENC_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.imem_we   = out_valid_q;
    assign bus.imem_addr = out_addr_q;
    assign bus.imem_data = out_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign word_count    = word_count_q;
`ifdef ENC_CHECKSUM_EN
    assign checksum      = checksum_q;
`endif

endmodule

// File: tb/tb_insn_encoder_loader.sv
// Scoreboard bench for insn_encoder_loader with a session-level reference model.
module tb_insn_encoder_loader;
    import isa_pkg::*;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned WORDS_MAX = 12;

    typedef struct {
        fmt_e        fmt;
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  aluop;
        logic [16:0] imm;
        logic [26:0] target;
        logic        last;
    } bundle_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy, done, overflow;
    logic [ADDR_W:0]   word_count;
`ifdef ENC_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    insn_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    insn_encoder_loader #(.ADDR_W(ADDR_W), .WORDS_MAX(WORDS_MAX)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
`ifdef ENC_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clock = ~clock;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  stall_lo = 0;
    int  stall_hi = 0;
    bit  rand_ready = 1'b0;
    int  acc_cyc = -1;
    logic [31:0] acc_data;
    wr_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc(input bundle_t b);
        logic [31:0] w;
        w = 32'(b.opcode) << 27;
        case (b.fmt)
            FMT_R:   w = w | (32'(b.rd) << 22) | (32'(b.rs) << 17) | (32'(b.rt) << 12)
                           | (32'(b.shamt) << 7) | (32'(b.aluop) << 2);
            FMT_I:   w = w | (32'(b.rd) << 22) | (32'(b.rs) << 17) | 32'(b.imm);
            FMT_JI:  w = w | 32'(b.target);
            default: w = w | (32'(b.rd) << 22);
        endcase
        return w;
    endfunction

    function automatic bundle_t mk(input int f, input int op, input int rd, input int rs, input int rt,
                                   input int sh, input int alu, input int imm, input int tgt, input bit last);
        bundle_t b;
        b.fmt = fmt_e'(2'(f)); b.opcode = 5'(op); b.rd = 5'(rd); b.rs = 5'(rs); b.rt = 5'(rt);
        b.shamt = 5'(sh); b.aluop = 5'(alu); b.imm = 17'(imm); b.target = 27'(tgt); b.last = last;
        return b;
    endfunction

    function automatic bundle_t rnd_bundle();
        return mk(int'($urandom_range(0, 3)), int'($urandom), int'($urandom), int'($urandom),
                  int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom), 1'b0);
    endfunction

    always @(posedge clock) cyc++;

    // Memory-side backpressure: scripted stall window, otherwise ready or random.
    always @(posedge clock) begin
        #1;
        if (cyc >= stall_lo && cyc < stall_hi) bus.imem_ready = 1'b0;
        else bus.imem_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
    end

    // Monitor: latency, stall stability, and in-order write checking.
    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
            sb.delete();
        end else begin
            if (acc_cyc == cyc) begin
                chk("latency_we", 64'(bus.imem_we), 64'(1));
                chk("latency_data", 64'(bus.imem_data), 64'(acc_data));
            end
            if (prev_stall)
                chk("stall_hold", {27'd0, bus.imem_we, bus.imem_addr, bus.imem_data},
                    {27'd0, 1'b1, prev_addr, prev_data});
            if (bus.imem_we && !bus.imem_ready)
                chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
            if (bus.imem_we && bus.imem_ready) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty scoreboard",
                             bus.imem_addr, bus.imem_data);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_addr", 64'(bus.imem_addr), 64'(e.addr));
                    chk("wr_data", 64'(bus.imem_data), 64'(e.data));
                end
            end
            prev_stall = bus.imem_we && !bus.imem_ready;
            prev_addr  = bus.imem_addr;
            prev_data  = bus.imem_data;
        end
    end

    task automatic set_fields(input bundle_t b);
        bus.in_fmt = b.fmt; bus.in_opcode = b.opcode; bus.in_rd = b.rd; bus.in_rs = b.rs;
        bus.in_rt = b.rt; bus.in_shamt = b.shamt; bus.in_aluop = b.aluop; bus.in_imm = b.imm;
        bus.in_target = b.target; bus.in_last = b.last;
    endtask

    task automatic drive_one(input bundle_t b, input logic [ADDR_W-1:0] addr, input bit stall, output int waits);
        wr_t e;
        set_fields(b);
        bus.in_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clock);
            if (bus.in_ready) break;
            waits++;
            if (waits > 200) begin
                n_vec++; n_err++;
                $display("FAIL accept_timeout: in_ready 0 for %0d cycles, required 1", waits);
                break;
            end
        end
        if (stall) begin stall_lo = cyc + 1; stall_hi = cyc + 4; end
        e.addr = addr; e.data = enc(b);
        sb.push_back(e);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        acc_cyc = cyc; acc_data = e.data;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        @(posedge clock); #1;
        start = 1'b1; base_addr = base;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic run_session(input logic [ADDR_W-1:0] base, input bundle_t bl[$],
                               input int stall_at, input bit want_b2b);
        int n_acc, waits, tot_waits;
        bit ovf;
`ifdef ENC_CHECKSUM_EN
        logic [31:0] cks = '0;
`endif
        n_acc = 0; ovf = 1'b0;
        for (int i = 0; i < bl.size(); i++) begin
            n_acc++;
`ifdef ENC_CHECKSUM_EN
            cks ^= enc(bl[i]);
`endif
            if (bl[i].last) break;
            if (n_acc == WORDS_MAX || int'(base) + i == (1 << ADDR_W) - 1) begin ovf = 1'b1; break; end
        end
        do_start(base);
        tot_waits = 0;
        for (int i = 0; i < n_acc; i++) begin
            drive_one(bl[i], ADDR_W'(int'(base) + i), i == stall_at, waits);
            tot_waits += waits;
        end
        if (ovf && bl.size() > n_acc) begin
            set_fields(bl[n_acc]);
            bus.in_valid = 1'b1;
            repeat (4) begin
                @(negedge clock);
                chk("ready_after_limit", 64'(bus.in_ready), 64'(0));
            end
            @(posedge clock); #1;
            bus.in_valid = 1'b0;
        end
        waits = 0;
        do begin
            @(negedge clock);
            waits++;
        end while (!done && waits < 300);
        chk("done", 64'(done), 64'(1));
        chk("busy", 64'(busy), 64'(0));
        chk("overflow", 64'(overflow), 64'(ovf));
        chk("word_count", 64'(word_count), 64'(n_acc));
        chk("sb_empty", 64'(sb.size()), 64'(0));
`ifdef ENC_CHECKSUM_EN
        chk("checksum", 64'(checksum), 64'(cks));
`endif
        if (want_b2b) chk("b2b_waits", 64'(tot_waits), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bundle_t bl[$];
        int n;
        bit has_last;
        reset = 1'b1; start = 1'b0; base_addr = '0;
        bus.in_valid = 1'b0;
        set_fields(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0));
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_we", 64'(bus.imem_we), 64'(0));
        chk("rst_addr", 64'(bus.imem_addr), 64'(0));
        chk("rst_data", 64'(bus.imem_data), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_flags", {61'd0, busy, done, overflow}, 64'(0));
        chk("rst_word_count", 64'(word_count), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;

        // Single R-type word.
        bl = '{mk(0, 0, 3, 1, 2, 0, 0, 0, 0, 1'b1)};
        run_session(5'h10, bl, -1, 1'b1);

        // Back-to-back R/I/JI at full throughput.
        bl = '{mk(0, 0, 4, 2, 0, 3, 4, 0, 0, 1'b0), mk(1, 5, 1, 0, 0, 0, 0, 5, 0, 1'b0),
               mk(2, 1, 0, 0, 0, 0, 0, 0, 'h100, 1'b1)};
        run_session(5'h04, bl, -1, 1'b1);

        // Three-cycle memory stall mid-stream.
        bl.delete();
        for (int i = 0; i < 5; i++) bl.push_back(rnd_bundle());
        bl[4].last = 1'b1;
        run_session(5'h00, bl, 1, 1'b0);

        // Address limit: only the top two addresses are written.
        bl.delete();
        for (int i = 0; i < 4; i++) bl.push_back(rnd_bundle());
        run_session(5'h1E, bl, -1, 1'b0);

        // WORDS_MAX reached without last, then with last on the final word.
        bl.delete();
        for (int i = 0; i < 14; i++) bl.push_back(rnd_bundle());
        run_session(5'h00, bl, -1, 1'b0);
        bl.delete();
        for (int i = 0; i < 12; i++) bl.push_back(rnd_bundle());
        bl[11].last = 1'b1;
        run_session(5'h02, bl, -1, 1'b0);

        // Reset one cycle after an accept while the write is stalled.
        do_start(5'h08);
        set_fields(rnd_bundle());
        bus.in_valid = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.in_ready && n < 50);
        stall_lo = cyc + 1; stall_hi = cyc + 60;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rstmid_we", 64'(bus.imem_we), 64'(0));
        chk("rstmid_state", {61'd0, busy, done, bus.in_ready}, 64'(0));
        chk("rstmid_word_count", 64'(word_count), 64'(0));
        stall_hi = 0;
        bl = '{rnd_bundle(), rnd_bundle()};
        bl[1].last = 1'b1;
        run_session(5'h08, bl, -1, 1'b1);

        // Randomized sessions under random backpressure.
        rand_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            bl.delete();
            has_last = ($urandom_range(0, 9) < 7);
            n = has_last ? int'($urandom_range(1, 14)) : 14;
            for (int i = 0; i < n; i++) bl.push_back(rnd_bundle());
            if (has_last) bl[n-1].last = 1'b1;
            run_session(ADDR_W'($urandom_range(0, 31)), bl, -1, 1'b0);
        end

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
